// File: rtl/led_pkg.sv
// Shared definitions for the LED frame path: frame geometry, GRB pixel layout
// and the sequencer state encoding.
package led_pkg;

    localparam int NUM_PIX = 6;
    localparam int PIX_W   = 24;

    // Bit offsets of each 8-bit channel within a 24-bit GRB word
    localparam int G_OFS = 16;
    localparam int R_OFS = 8;
    localparam int B_OFS = 0;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } pixel_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCALE,
        ST_SEND,
        ST_GAP
    } seq_state_t;

endpackage

// File: rtl/led_scaler.sv
// Single-channel brightness scaler: y = (c * (b+1)) >> 8, so b=255 is identity.
module led_scaler (
    input  logic [7:0] c,
    input  logic [7:0] b,
    output logic [7:0] y
);

    assign y = 8'(({8'd0, c} * ({8'd0, b} + 16'd1)) >> 8);

endmodule

// File: rtl/led_frame_sequencer.sv
// Frame feeder for the WS2812 driver: working buffer, brightness-scaled shadow
// frame, load/done handshake and latch-gap timing.
module led_frame_sequencer
    import led_pkg::*;
#(
    parameter int RESET_CYCLES = 7200
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pix_we,
    input  logic [2:0]                 pix_idx,
    input  logic [23:0]                pix_grb,
    input  logic [7:0]                 bright,
    input  logic                       commit,
    input  logic                       done,
    output logic [PIX_W*NUM_PIX-1:0]   rgb,
    output logic                       load,
    output logic                       busy,
    output logic                       frame_sent
);

    localparam logic [2:0]       LAST_PIX = 3'(NUM_PIX - 1);
    localparam int               GAP_W    = $clog2(RESET_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(RESET_CYCLES - 1);

    seq_state_t                    state, state_n;
    pixel_t                        buf_q [NUM_PIX];
    logic [NUM_PIX-1:0][PIX_W-1:0] shadow_q;
    logic [2:0]                    pix_cnt;
    logic [GAP_W-1:0]              gap_cnt;
    logic [7:0]                    bright_q;
    logic                          pending, pending_n, start;
    pixel_t                        cur;
    logic [PIX_W-1:0]              scaled;

    assign cur = buf_q[pix_cnt];

    led_scaler u_scale_g (.c(cur.g), .b(bright_q), .y(scaled[G_OFS +: 8]));
    led_scaler u_scale_r (.c(cur.r), .b(bright_q), .y(scaled[R_OFS +: 8]));
    led_scaler u_scale_b (.c(cur.b), .b(bright_q), .y(scaled[B_OFS +: 8]));

    always_comb begin
        state_n = state;
        start   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (commit || pending) begin
                    state_n = ST_SCALE;
                    start   = 1'b1;
                end
            end
            ST_SCALE: if (pix_cnt == LAST_PIX) state_n = ST_SEND;
            ST_SEND:  if (done) state_n = ST_GAP;
            ST_GAP:   if (gap_cnt == '0) state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
        // Any number of commits while busy collapse into one pending frame
        pending_n = start ? 1'b0 : (pending | commit);
    end

    assign frame_sent = (state == ST_GAP) && (gap_cnt == '0);
    assign rgb        = shadow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            pending  <= 1'b0;
            load     <= 1'b0;
            busy     <= 1'b0;
            pix_cnt  <= '0;
            gap_cnt  <= '0;
            bright_q <= '0;
            shadow_q <= '0;
            for (int i = 0; i < NUM_PIX; i++) buf_q[i] <= '0;
        end else begin
            state   <= state_n;
            pending <= pending_n;
            load    <= (state_n == ST_SEND);
            busy    <= (state_n != ST_IDLE) || pending_n;

            if (start) bright_q <= bright;

            pix_cnt <= (state == ST_SCALE && pix_cnt != LAST_PIX) ? pix_cnt + 3'd1 : '0;
            if (state == ST_SCALE) shadow_q[pix_cnt] <= scaled;

            if (state == ST_SEND && done)
                gap_cnt <= GAP_LAST;
            else if (state == ST_GAP && gap_cnt != '0)
                gap_cnt <= gap_cnt - 1'b1;

            // Writes land before SCALE reads, so a write alongside commit joins that frame
            if (pix_we && pix_idx <= LAST_PIX) buf_q[pix_idx] <= pix_grb;
        end
    end

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Directed bench for led_frame_sequencer with a 16-cycle latch gap.
module tb_led_frame_sequencer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         pix_we = 1'b0;
    logic [2:0]   pix_idx = '0;
    logic [23:0]  pix_grb = '0;
    logic [7:0]   bright = '0;
    logic         commit = 1'b0;
    logic         done = 1'b0;
    logic [143:0] rgb;
    logic         load, busy, frame_sent;

    int checks = 0;
    int failures = 0;

    led_frame_sequencer #(.RESET_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .pix_we(pix_we), .pix_idx(pix_idx), .pix_grb(pix_grb),
        .bright(bright), .commit(commit), .done(done), .rgb(rgb), .load(load),
        .busy(busy), .frame_sent(frame_sent)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] idx, input logic [23:0] val);
        pix_we = 1'b1; pix_idx = idx; pix_grb = val;
        step();
        pix_we = 1'b0;
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        step();
        commit = 1'b0;
    endtask

    // Bounded wait for the end-of-gap pulse; leaves the bench in that cycle
    task automatic wait_sent(input string tag);
        logic got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            step();
            got = frame_sent;
        end
        chk(tag, {143'd0, got}, 144'd1);
    endtask

    initial begin
        step(); step();
        rst = 1'b0;
        chk("reset_rgb", rgb, '0);
        chk("reset_load", {143'd0, load}, '0);
        chk("reset_busy", {143'd0, busy}, '0);
        chk("reset_frame_sent", {143'd0, frame_sent}, '0);

        // Write alongside commit, full brightness
        bright = 8'd255;
        pix_we = 1'b1; pix_idx = 3'd0; pix_grb = 24'hFF8040; commit = 1'b1;
        step();
        pix_we = 1'b0; commit = 1'b0;
        chk("busy_after_commit", {143'd0, busy}, 144'd1);
        repeat (5) step();
        chk("load_before_t7", {143'd0, load}, '0);
        step();
        chk("load_at_t7", {143'd0, load}, 144'd1);
        chk("rgb_bright255", rgb, {120'd0, 24'hFF8040});

        // done in SEND: load drops next cycle, gap lasts 16 cycles
        done = 1'b1;
        step();
        done = 1'b0;
        chk("load_drop_after_done", {143'd0, load}, '0);
        repeat (14) step();
        chk("frame_sent_early", {143'd0, frame_sent}, '0);
        step();
        chk("frame_sent_at_gap_end", {143'd0, frame_sent}, 144'd1);
        chk("busy_in_last_gap", {143'd0, busy}, 144'd1);
        step();
        chk("frame_sent_one_cycle", {143'd0, frame_sent}, '0);
        chk("busy_idle", {143'd0, busy}, '0);

        // Out-of-range index and stray done in IDLE change nothing
        wr(3'd6, 24'hFFFFFF);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("done_idle_busy", {143'd0, busy}, '0);
        chk("done_idle_load", {143'd0, load}, '0);

        // Half brightness, pixel 2 added
        wr(3'd2, 24'hFF8040);
        bright = 8'd127;
        pulse_commit();
        repeat (6) step();
        chk("load_bright127", {143'd0, load}, 144'd1);
        chk("rgb_bright127", rgb, {72'd0, 24'h7F4020, 24'h0, 24'h7F4020});

        // Two commits during SEND collapse to one follow-on frame
        pulse_commit();
        step();
        pulse_commit();
        chk("load_held_in_send", {143'd0, load}, 144'd1);
        bright = 8'd255;
        done = 1'b1;
        step();
        done = 1'b0;
        wr(3'd5, 24'h00FF00);
        wait_sent("pending_gap_sent");
        step();
        chk("busy_pending_idle", {143'd0, busy}, 144'd1);
        repeat (6) step();
        chk("pending_load_early", {143'd0, load}, '0);
        step();
        chk("pending_load", {143'd0, load}, 144'd1);
        chk("rgb_pending_frame",
            rgb, {24'h00FF00, 24'h0, 24'h0, 24'hFF8040, 24'h0, 24'hFF8040});
        done = 1'b1;
        step();
        done = 1'b0;
        wait_sent("second_gap_sent");
        step();
        repeat (10) step();
        chk("no_third_frame_load", {143'd0, load}, '0);
        chk("no_third_frame_busy", {143'd0, busy}, '0);

        // Zero brightness blanks every slot
        bright = 8'd0;
        pulse_commit();
        repeat (6) step();
        chk("load_bright0", {143'd0, load}, 144'd1);
        chk("rgb_bright0", rgb, '0);
        done = 1'b1;
        step();
        done = 1'b0;
        wait_sent("bright0_gap_sent");
        step();

        // Reset mid-SEND clears outputs and the working buffer
        bright = 8'd255;
        pulse_commit();
        repeat (6) step();
        chk("load_before_rst", {143'd0, load}, 144'd1);
        chk("rgb_before_rst", rgb[23:0], {120'd0, 24'hFF8040});
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_load", {143'd0, load}, '0);
        chk("rst_rgb", rgb, '0);
        chk("rst_busy", {143'd0, busy}, '0);
        pulse_commit();
        repeat (6) step();
        chk("post_rst_load", {143'd0, load}, 144'd1);
        chk("post_rst_buffer_cleared", rgb, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_frame_sequencer.md
# led_frame_sequencer

Upstream feeder for the WS2812 strip driver: holds a 6-pixel working frame buffer written one pixel at a time, applies a global brightness scale on commit, and presents the scaled 144-bit frame with a `load` request to the driver. It holds `load` until the driver's `done` pulse, then enforces the strip latch (reset) gap before accepting the next frame. It sits between the MCU-facing register/SPI logic and the strip driver.

## Interface
- `NUM_PIX`, 6: pixels per frame; frame width is 24*NUM_PIX.
- `RESET_CYCLES`, 7200: latch-gap length in clk cycles (300 µs at 24 MHz).
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `pix_we`  in  1  write strobe for the working buffer.
- `pix_idx`  in  3  pixel index 0..NUM_PIX-1; writes with idx ≥ NUM_PIX are ignored.
- `pix_grb`  in  24  pixel colour, {G[23:16], R[15:8], B[7:0]}.
- `bright`  in  8  global brightness, sampled once per commit.
- `commit`  in  1  one-cycle request to send the working buffer.
- `done`  in  1  driver end-of-frame pulse.
- `rgb`  out  144  scaled frame; pixel i at rgb[24*i+23 : 24*i].
- `load`  out  1  frame request to driver (level).
- `busy`  out  1  high when not IDLE or a commit is pending.
- `frame_sent`  out  1  one-cycle pulse at end of latch gap.

## Operation
- Working buffer: NUM_PIX × 24-bit registers, writable every cycle in every state; never read by the driver directly.
- Shadow frame (`rgb`) is written only in SCALE; it is stable in all other states.
- Scaling per channel: out = (c × (b+1)) >> 8, where c and b are 8-bit values, the product is 16-bit and the result is 8-bit. b=255 gives identity; b=0 gives c>>8 = 0.
- FSM states: IDLE, SCALE, SEND, GAP.
  - IDLE: on `commit` or pending → SCALE; latch `bright`; pixel counter = 0; clear pending.
  - SCALE: one pixel per cycle, with three channel scalers in parallel; writes shadow slot counter; after pixel NUM_PIX-1 → SEND.
  - SEND: `load`=1; on `done` → GAP; `load` drops the next cycle.
  - GAP: counts RESET_CYCLES cycles with `load`=0; in the final cycle `frame_sent`=1, then → IDLE.
- `commit` while not IDLE sets pending; multiple commits collapse to one. A pending commit starts SCALE on the first IDLE cycle, so the frame uses buffer contents at that time.
- A `pix_we` in the same cycle as `commit` is included in that frame, because buffer writes resolve before SCALE reads.
- A `done` outside SEND is ignored.
- Reset at any point: state IDLE; buffer, shadow and pending cleared; counters 0.

## Timing
- Reset values: `rgb`=0, `load`=0, `busy`=0, `frame_sent`=0.
- Commit in IDLE at cycle t: SCALE covers t+1..t+NUM_PIX, and `load`=1 from t+NUM_PIX+1.
- `done` high at cycle d (in SEND): `load`=0 at d+1; GAP spans d+1..d+RESET_CYCLES; `frame_sent` is high at d+RESET_CYCLES; IDLE at d+RESET_CYCLES+1.
- `load` is registered and falls exactly one cycle after `done`, so the driver never retransmits the same frame.
- `busy` is registered and rises the cycle after a commit is accepted.
- Back-to-back: a pending commit enters SCALE the cycle after IDLE is reached.

## Structure
- Shared package `led_pkg`: NUM_PIX, GRB field offsets, pixel typedef (24-bit packed struct g/r/b), sequencer state enum.
- Sub-module `led_scaler`: combinational 8×9-bit multiply with shift; instantiated three times (G, R, B).
- Latch-gap counter is a local down-counter; it is not shared with driver timing counters.

## Test plan
- Reset, write pixel 0 = 0xFF8040, bright=255, commit → rgb[23:0]=0xFF8040; `load` high 7 cycles after commit.
- Bright=127, pixel 2 = 0xFF8040 → rgb[71:48]=0x7F4020. Bright=0 → all slots 0.
- Pulse `done` in SEND → `load` low next cycle; `frame_sent` after exactly RESET_CYCLES cycles (use RESET_CYCLES=16 in sim).
- Commit twice during SEND, and write pixel 5 = 0x00FF00 during GAP → exactly one extra frame; it contains 0x00FF00 at rgb[143:120].
- `pix_idx`=6 write is ignored; `done` in IDLE is ignored; `rst` mid-SEND → `load`=0, `rgb`=0, `busy`=0 next cycle.
